btn_state_ctl: RTL

- Input-side counterpart of the seven-segment display controller: turns the five board pushbuttons into the 3-bit `state` code the display controller consumes.
- Raw buttons pass through a 2-flop synchronizer, a per-button debounce counter, and a rising-edge detector.
- A small state register then applies priority and toggle rules to the edge events.
- Sits between the board button pins and the display controller's `state` input.

---
 rtl/btn_state_ctl.sv | 105 ++++++++++
 1 files changed

// File: rtl/btn_state_ctl.sv
// Pushbutton front end: sync, debounce and rising-edge detect five buttons,
// then fold the press events into the 3-bit display mode code.
module btn_state_ctl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnu,
  input  logic       btnd,
  input  logic       btnl,
  input  logic       btnr,
  input  logic       btnc,
  output logic [2:0] state,
  output logic       state_upd,
  output logic [4:0] btn_db
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_UP    = 3'b001,
    ST_LEFT  = 3'b010,
    ST_RIGHT = 3'b011,
    ST_DOWN  = 3'b100,
    ST_DEF   = 3'b101
  } state_e;

  logic [4:0]         raw;
  logic [4:0]         s1_q, s1_d;
  logic [4:0]         s2_q, s2_d;
  logic [4:0]         db_q, db_d;
  logic [4:0]         db_prev_q, db_prev_d;
  logic [4:0][CW-1:0] cnt_q, cnt_d;
  logic [4:0]         press;
  state_e             state_q, state_d;
  state_e             tgt;
  logic               upd_q, upd_d;

  assign raw = {btnc, btnu, btnd, btnl, btnr};

  always_comb begin
    s1_d      = raw;
    s2_d      = s1_q;
    db_d      = db_q;
    cnt_d     = cnt_q;
    db_prev_d = db_q;
    for (int i = 0; i < 5; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  always_comb begin
    state_d = state_q;
    upd_d   = 1'b0;
    tgt     = state_q;
    priority case (1'b1)
      press[4]: tgt = ST_DEF;
      press[3]: tgt = ST_UP;
      press[2]: tgt = ST_DOWN;
      press[1]: tgt = ST_LEFT;
      press[0]: tgt = ST_RIGHT;
      default:  tgt = state_q;
    endcase
    // Re-pressing the active direction toggles back to DEFAULT
    if (|press) begin
      upd_d   = 1'b1;
      state_d = (tgt == state_q) ? ST_DEF : tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      cnt_q     <= '0;
      state_q   <= ST_DEF;
      upd_q     <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      upd_q     <= upd_d;
    end
  end

  assign state     = state_q;
  assign state_upd = upd_q;
  assign btn_db    = db_q;

endmodule
